pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline registers (PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB).

---
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the five pipeline registers, with a BUSY/DONE
// sequencer for the multi-cycle divider and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              ID_UseRs,
    input  logic              ID_UseRt,
    input  logic              EXE_ReadMem,
    input  logic [4:0]        EXE_Dst,
    input  logic              EXE_IsDiv,
    input  logic              IF_Stall,
    input  logic              MEM_Stall,
    input  logic              Except_Flush,
    output logic              IF_PCWr,
    output logic              IF_IDWr,
    output logic              ID_EXEWr,
    output logic              EXE_MEMWr,
    output logic              MEM_WBWr,
    output logic              IFID_Flush,
    output logic              IDEXE_Flush,
    output logic              EXEMEM_Flush,
    output logic              MEMWB_Flush,
    output logic              div_start,
    output logic              div_abort,
    output logic              div_busy,
    output logic [PERF_W-1:0] perf_stall
);

    // state  | meaning
    // IDLE   | no divide in flight; a DIV in EXE launches the divider
    // BUSY   | divider running, front of pipe held, cnt counts down
    // DONE   | result ready, divide leaves EXE once MEM is not stalled
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int              CNT_W    = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PERF_W-1:0] r_perf;

    logic w_start_cond;
    logic w_busy;
    logic w_load_use;

    // Launch condition ignores Except_Flush so the abort can see a start that was suppressed.
    assign w_start_cond = (r_state == S_IDLE) && EXE_IsDiv && !MEM_Stall;
    assign w_busy       = (r_state == S_BUSY);
    assign w_load_use   = EXE_ReadMem && (EXE_Dst != 5'd0) &&
                          ((ID_UseRs && (ID_rs == EXE_Dst)) || (ID_UseRt && (ID_rt == EXE_Dst)));
    assign perf_stall   = r_perf;

    always_comb begin
        IF_PCWr      = 1'b1;
        IF_IDWr      = 1'b1;
        ID_EXEWr     = 1'b1;
        EXE_MEMWr    = 1'b1;
        MEM_WBWr     = 1'b1;
        IFID_Flush   = 1'b0;
        IDEXE_Flush  = 1'b0;
        EXEMEM_Flush = 1'b0;
        MEMWB_Flush  = 1'b0;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        div_busy     = 1'b0;
        if (!rst) begin
            IF_PCWr      = 1'b0;
            IF_IDWr      = 1'b0;
            ID_EXEWr     = 1'b0;
            EXE_MEMWr    = 1'b0;
            MEM_WBWr     = 1'b0;
            IFID_Flush   = 1'b1;
            IDEXE_Flush  = 1'b1;
            EXEMEM_Flush = 1'b1;
            MEMWB_Flush  = 1'b1;
        end else begin
            div_busy  = w_busy;
            div_start = w_start_cond && !Except_Flush;
            if (Except_Flush) begin
                IFID_Flush   = 1'b1;
                IDEXE_Flush  = 1'b1;
                EXEMEM_Flush = 1'b1;
                div_abort    = w_busy || w_start_cond;
            end else if (MEM_Stall) begin
                IF_PCWr     = 1'b0;
                IF_IDWr     = 1'b0;
                ID_EXEWr    = 1'b0;
                EXE_MEMWr   = 1'b0;
                MEM_WBWr    = 1'b0;
                MEMWB_Flush = 1'b1;
            end else if (w_busy || w_start_cond) begin
                IF_PCWr      = 1'b0;
                IF_IDWr      = 1'b0;
                ID_EXEWr     = 1'b0;
                EXEMEM_Flush = 1'b1;
            end else if (w_load_use) begin
                IF_PCWr     = 1'b0;
                IF_IDWr     = 1'b0;
                IDEXE_Flush = 1'b1;
            end else if (IF_Stall) begin
                IF_PCWr    = 1'b0;
                IFID_Flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_perf  <= '0;
        end else begin
            if (Except_Flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_cond) begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                    S_BUSY: begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) r_state <= S_DONE;
                    end
                    S_DONE: begin
                        if (!MEM_Stall) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            if (!IF_PCWr && (r_perf != {PERF_W{1'b1}})) r_perf <= r_perf + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus, all compared
// every cycle against a priority-rule model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;
    localparam int PW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    ID_rs, ID_rt, EXE_Dst;
    logic          ID_UseRs, ID_UseRt, EXE_ReadMem, EXE_IsDiv;
    logic          IF_Stall, MEM_Stall, Except_Flush;
    logic          IF_PCWr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr;
    logic          IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush;
    logic          div_start, div_abort, div_busy;
    logic [PW-1:0] perf_stall;

    pipeline_hazard_ctrl #(.DIV_LATENCY(LAT), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .EXE_ReadMem(EXE_ReadMem), .EXE_Dst(EXE_Dst), .EXE_IsDiv(EXE_IsDiv),
        .IF_Stall(IF_Stall), .MEM_Stall(MEM_Stall), .Except_Flush(Except_Flush),
        .IF_PCWr(IF_PCWr), .IF_IDWr(IF_IDWr), .ID_EXEWr(ID_EXEWr),
        .EXE_MEMWr(EXE_MEMWr), .MEM_WBWr(MEM_WBWr),
        .IFID_Flush(IFID_Flush), .IDEXE_Flush(IDEXE_Flush),
        .EXEMEM_Flush(EXEMEM_Flush), .MEMWB_Flush(MEMWB_Flush),
        .div_start(div_start), .div_abort(div_abort), .div_busy(div_busy),
        .perf_stall(perf_stall)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: divide progress as "busy cycles still to run" plus a result-ready flag.
    int m_left  = 0;
    bit m_done  = 0;
    int m_perf  = 0;
    logic [11:0] last_act;

    // Bit order: PCWr IFIDWr IDEXEWr EXEMEMWr MEMWBWr | IFID IDEXE EXEMEM MEMWB flush | start abort busy
    function automatic logic [11:0] model_out();
        logic [4:0] wr;
        logic [3:0] fl;
        logic       st, ab, bz, launch, lu;
        wr = 5'b11111; fl = 4'b0000; st = 0; ab = 0; bz = 0;
        if (!rst) return 12'b00000_1111_000;
        bz     = (m_left > 0);
        launch = !bz && !m_done && EXE_IsDiv && !MEM_Stall;
        st     = launch && !Except_Flush;
        lu     = EXE_ReadMem && EXE_Dst != 0 &&
                 ((ID_UseRs && ID_rs == EXE_Dst) || (ID_UseRt && ID_rt == EXE_Dst));
        if (Except_Flush) begin
            fl = 4'b1110; ab = bz || launch;
        end else if (MEM_Stall) begin
            wr = 5'b00000; fl = 4'b0001;
        end else if (bz || launch) begin
            wr = 5'b00011; fl = 4'b0010;
        end else if (lu) begin
            wr = 5'b00111; fl = 4'b0100;
        end else if (IF_Stall) begin
            wr = 5'b01111; fl = 4'b1000;
        end
        return {wr, fl, st, ab, bz};
    endfunction

    task automatic model_update(input logic [11:0] e);
        if (!rst) begin
            m_left = 0; m_done = 0; m_perf = 0;
            return;
        end
        if (Except_Flush) begin
            m_left = 0; m_done = 0;
        end else if (e[2]) begin
            m_left = LAT;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1;
        end else if (m_done && !MEM_Stall) begin
            m_done = 0;
        end
        if (!e[11] && m_perf < (1 << PW) - 1) m_perf = m_perf + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic step();
        logic [11:0] e, a;
        #1;
        e = model_out();
        a = {IF_PCWr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr,
             IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush,
             div_start, div_abort, div_busy};
        last_act = a;
        check("outputs", int'(a), int'(e));
        check("perf_stall", int'(perf_stall), m_perf);
        @(posedge clk);
        model_update(e);
        @(negedge clk);
    endtask

    task automatic quiet();
        ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0; EXE_ReadMem = 0; EXE_Dst = 0;
        EXE_IsDiv = 0; IF_Stall = 0; MEM_Stall = 0; Except_Flush = 0;
    endtask

    int starts, stalls;

    initial begin
        quiet();
        rst = 0;
        @(negedge clk);
        // T1 reset
        step();
        step();
        check("reset_outs", int'(last_act), int'(12'b00000_1111_000));
        check("reset_perf", int'(perf_stall), 0);
        rst = 1;
        step();
        check("idle_outs", int'(last_act), int'(12'b11111_0000_000));

        // T2 load-use, then with r0 destination
        EXE_ReadMem = 1; EXE_Dst = 5; ID_rs = 5; ID_UseRs = 1;
        step();
        check("load_use", int'(last_act), int'(12'b00111_0100_000));
        quiet(); step();
        EXE_ReadMem = 1; EXE_Dst = 0; ID_rs = 0; ID_UseRs = 1;
        step();
        check("load_use_r0", int'(last_act), int'(12'b11111_0000_000));
        quiet(); step();

        // T3 divide: c0..c4 stalled, c5 DONE advances, c6 IDLE
        starts = 0; stalls = 0;
        EXE_IsDiv = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            starts += int'(last_act[2]);
            stalls += int'(!last_act[11]);
        end
        check("div_done_adv", int'(last_act), int'(12'b11111_0000_000));
        EXE_IsDiv = 0;
        step();
        starts += int'(last_act[2]);
        check("div_start_cnt", starts, 1);
        check("div_stall_cnt", stalls, 1 + LAT);

        // T4 abort on 2nd BUSY cycle
        EXE_IsDiv = 1; step();
        EXE_IsDiv = 0; step();
        Except_Flush = 1; step();
        check("abort", int'(last_act), int'(12'b11111_1110_011));
        Except_Flush = 0; step();
        check("after_abort", int'(last_act), int'(12'b11111_0000_000));

        // T5 MEM_Stall held in DONE
        EXE_IsDiv = 1; step();
        EXE_IsDiv = 0;
        for (int c = 0; c < LAT; c++) step();
        MEM_Stall = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("done_memstall", int'(last_act), int'(12'b00000_0001_000));
        end
        MEM_Stall = 0; step();
        check("done_release", int'(last_act), int'(12'b11111_0000_000));
        step();

        // T6 saturation and simultaneous events
        IF_Stall = 1;
        for (int c = 0; c < 20; c++) step();
        check("perf_sat", int'(perf_stall), 15);
        MEM_Stall = 1; Except_Flush = 1;
        step();
        check("simultaneous", int'(last_act), int'(12'b11111_1110_000));
        quiet(); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) >= 2);
            ID_rs        = 5'($urandom_range(0, 3));
            ID_rt        = 5'($urandom_range(0, 3));
            ID_UseRs     = 1'($urandom_range(0, 1));
            ID_UseRt     = 1'($urandom_range(0, 1));
            EXE_ReadMem  = ($urandom_range(0, 99) < 40);
            EXE_Dst      = 5'($urandom_range(0, 3));
            EXE_IsDiv    = ($urandom_range(0, 99) < 25);
            IF_Stall     = ($urandom_range(0, 99) < 20);
            MEM_Stall    = ($urandom_range(0, 99) < 15);
            Except_Flush = ($urandom_range(0, 99) < 4);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
